// File: rtl/pdm_serializer_if.sv
// Word handshake bundle for pdm_serializer: the producer drives data/load,
// and the serializer returns ready while its holding buffer is empty.
interface pdm_serializer_if;
  logic [15:0] data;
  logic        load;
  logic        ready;

  modport master (output data, output load, input ready);
  modport slave  (input data, input load, output ready);
endinterface

// File: rtl/pdm_serializer.sv
// PDM/PWM word serializer: streams 16-bit words onto AUD_PWM, one bit per CLOCK_DIV clocks.
// Optional saturating underrun counter is enabled by defining SERIALIZER_UNDERRUN_EN.
module pdm_serializer #(
  parameter int CLOCK_DIV = 100,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  pdm_serializer_if.slave  bus,
  output logic             done,
  output logic             pwm_o,
  output logic             aud_sd_o
`ifdef SERIALIZER_UNDERRUN_EN
  ,
  output logic [15:0]      underrun_o
`endif
);

  localparam int DIV_W = $clog2(CLOCK_DIV);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [DIV_W-1:0] r_div;
  logic [0:0]       r_state;
  logic [3:0]       r_bit_cnt;
  logic [15:0]      r_shreg;
  logic [15:0]      r_hold;
  logic             r_hold_valid;
  logic             r_pwm;
  logic             r_done;
  logic             r_sd;

  logic             w_tick;
  logic             w_last;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [15:0]      w_shifted;

  assign w_tick      = (r_div == DIV_W'(CLOCK_DIV - 1));
  assign w_last      = (r_bit_cnt == 4'd15);
  assign w_first_bit = MSB_FIRST ? r_hold[15] : r_hold[0];
  assign w_next_bit  = MSB_FIRST ? r_shreg[14] : r_shreg[1];
  assign w_shifted   = MSB_FIRST ? {r_shreg[14:0], 1'b0} : {1'b0, r_shreg[15:1]};

  // ready follows the holding register directly, so a word can never be
  // accepted in the same cycle the hold is drained into the shifter.
  assign bus.ready = ~r_hold_valid;
  assign done      = r_done;
  assign pwm_o     = r_pwm;
  assign aud_sd_o  = r_sd;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours regardless of order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div        <= '0;
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_pwm        <= 1'b0;
      r_done       <= 1'b0;
      r_sd         <= 1'b0;
    end else if (!enable) begin
      r_div        <= '0;
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_hold_valid <= 1'b0;
      r_pwm        <= 1'b0;
      r_done       <= 1'b0;
      r_sd         <= 1'b0;
    end else begin
      r_sd   <= 1'b1;
      r_done <= 1'b0;
      r_div  <= w_tick ? '0 : r_div + DIV_W'(1);

      if (bus.load && !r_hold_valid) begin
        r_hold       <= bus.data;
        r_hold_valid <= 1'b1;
      end

      if (w_tick) begin
        if (r_state == S_IDLE || w_last) begin
          if (r_state == S_SHIFT) r_done <= 1'b1;
          // A waiting word starts on the same tick the previous one ends: no gap bit.
          if (r_hold_valid) begin
            r_shreg      <= r_hold;
            r_pwm        <= w_first_bit;
            r_bit_cnt    <= '0;
            r_hold_valid <= 1'b0;
            r_state      <= S_SHIFT;
          end else begin
            r_pwm   <= 1'b0;
            r_state <= S_IDLE;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_shreg   <= w_shifted;
          r_pwm     <= w_next_bit;
        end
      end
    end
  end

`ifdef SERIALIZER_UNDERRUN_EN
  logic        w_underrun_evt;
  logic [15:0] r_underrun;

  // A word finished with nothing queued behind it; survives enable low.
  assign w_underrun_evt = enable && w_tick && (r_state == S_SHIFT) && w_last && !r_hold_valid;
  assign underrun_o     = r_underrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_underrun <= '0;
    end else if (w_underrun_evt && (r_underrun != 16'hFFFF)) begin
      r_underrun <= r_underrun + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pdm_serializer.sv
// Self-checking bench for pdm_serializer (CLOCK_DIV=4): a negedge monitor rebuilds each
// transmitted word from the 64 pwm_o samples preceding its done pulse.
module tb_pdm_serializer;
  localparam int DIV = 4;
  localparam int WCLK = 16 * DIV;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic done, pwm, aud_sd;
  logic done_l, pwm_l, aud_sd_l;
`ifdef SERIALIZER_UNDERRUN_EN
  logic [15:0] underrun, underrun_l;
`endif

  always #5 clock = ~clock;

  pdm_serializer_if bus ();
  pdm_serializer_if lbus ();

  pdm_serializer #(.CLOCK_DIV(DIV), .MSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus),
    .done(done), .pwm_o(pwm), .aud_sd_o(aud_sd)
`ifdef SERIALIZER_UNDERRUN_EN
    , .underrun_o(underrun)
`endif
  );

  pdm_serializer #(.CLOCK_DIV(DIV), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .enable(enable), .bus(lbus),
    .done(done_l), .pwm_o(pwm_l), .aud_sd_o(aud_sd_l)
`ifdef SERIALIZER_UNDERRUN_EN
    , .underrun_o(underrun_l)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: words reconstructed MSB-first from the pwm history, plus bit-steadiness.
  int          cyc = 0;
  logic        hist [0:127];
  logic [15:0] got_word [$];
  bit          got_steady [$];
  int          got_cyc [$];
  logic [15:0] exp_q [$];

  always @(negedge clock) begin
    logic [15:0] w;
    bit          st;
    logic        b;
    hist[cyc % 128] = pwm;
    if (done === 1'b1 && cyc >= WCLK) begin
      st = 1'b1;
      w  = '0;
      for (int i = 0; i < 16; i++) begin
        b = hist[(cyc - WCLK + DIV * i) % 128];
        for (int j = 1; j < DIV; j++)
          if (hist[(cyc - WCLK + DIV * i + j) % 128] !== b) st = 1'b0;
        w[15 - i] = b;
      end
      got_word.push_back(w);
      got_steady.push_back(st);
      got_cyc.push_back(cyc);
    end
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_logs();
    got_word.delete();
    got_steady.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; offers one word and returns one negedge later.
  task automatic send(input logic [15:0] w, output bit ok);
    int t = 0;
    while (bus.ready !== 1'b1 && t < 500) begin
      @(negedge clock);
      t++;
    end
    ok = (bus.ready === 1'b1);
    if (!ok) return;
    bus.data = w;
    bus.load = 1'b1;
    exp_q.push_back(w);
    @(negedge clock);
    bus.load = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int t = 0;
    while (got_word.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    ok = (got_word.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    bus.load = 1'b0; bus.data = '0; lbus.load = 1'b0; lbus.data = '0;
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    n_checks++; if (aud_sd !== 1'b0) begin n_fail++; $display("FAIL reset_aud_sd: got %b expected 0", aud_sd); end
`ifdef SERIALIZER_UNDERRUN_EN
    n_checks++; if (underrun !== 16'h0) begin n_fail++; $display("FAIL reset_underrun: got %0h expected 0", underrun); end
`endif
    clks(2);
    reset = 1'b0;
    enable = 1'b1;
    clks(2);
    n_checks++; if (aud_sd !== 1'b1) begin n_fail++; $display("FAIL aud_sd_follow: got %b expected 1", aud_sd); end
  endtask

  task automatic test_single();
    bit ok;
    int c;
    clear_logs();
    send(16'hA5C3, ok);
    n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_after_load: got %b expected 0", bus.ready); end
    c = 1;
    while (pwm !== 1'b1 && c < 10) begin
      @(negedge clock);
      c++;
    end
    n_checks++; if ((c - 1) < 1 || (c - 1) > DIV) begin n_fail++; $display("FAIL single_latency: got %0d expected 1..%0d", c - 1, DIV); end
    wait_words(1, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d words expected 1", got_word.size()); end
    if (ok) begin
      n_checks++; if (got_word[0] !== 16'hA5C3 || !got_steady[0]) begin n_fail++; $display("FAIL single_word: got %0h steady %0b expected a5c3 steady 1", got_word[0], got_steady[0]); end
    end
    clks(1);
    n_checks++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL single_idle_pwm: got %b expected 0", pwm); end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL single_idle_ready: got %b expected 1", bus.ready); end
    clks(30);
    n_checks++; if (got_word.size() != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", got_word.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok;
    clear_logs();
    send(16'hFFFF, ok1);
    send(16'h0000, ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accept: got %0b%0b expected 11", ok1, ok2); end
    wait_words(2, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d words expected 2", got_word.size()); end
    if (ok) begin
      n_checks++; if (got_word[0] !== 16'hFFFF || got_word[1] !== 16'h0000 || !got_steady[0] || !got_steady[1]) begin
        n_fail++; $display("FAIL b2b_words: got %0h,%0h expected ffff,0000", got_word[0], got_word[1]);
      end
      n_checks++; if (got_cyc[1] - got_cyc[0] != WCLK) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d expected %0d", got_cyc[1] - got_cyc[0], WCLK); end
    end
    clks(2);
    n_checks++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_pwm: got %b expected 0", pwm); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    clear_logs();
    bus.load = 1'b1;
    for (int i = 0; i < 700; i++) begin
      bus.data = 16'($urandom());
      if (bus.ready === 1'b1) exp_q.push_back(bus.data);
      @(negedge clock);
    end
    bus.load = 1'b0;
    wait_words(exp_q.size(), 300, ok);
    n_checks++; if (got_word.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_word.size(), exp_q.size()); end
    n_checks++; if (exp_q.size() < 10 || exp_q.size() > 13) begin n_fail++; $display("FAIL bp_accept_rate: got %0d expected 10..13", exp_q.size()); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_word.size(); i++)
      if (got_word[i] !== exp_q[i] || !got_steady[i]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_words: got %0d mismatching words expected 0", bad); end
  endtask

  task automatic test_abort();
    bit ok;
    int c;
    clear_logs();
    send(16'h8001, ok);
    c = 0;
    while (pwm !== 1'b1 && c < 10) begin
      @(negedge clock);
      c++;
    end
    send(16'h1234, ok);
    clks(7 * DIV);
    n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL abort_hold_full: got %b expected 0", bus.ready); end
    enable = 1'b0;
    @(negedge clock);
    n_checks++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL abort_pwm: got %b expected 0", pwm); end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", bus.ready); end
    n_checks++; if (aud_sd !== 1'b0) begin n_fail++; $display("FAIL abort_aud_sd: got %b expected 0", aud_sd); end
    bus.data = 16'h5555;
    bus.load = 1'b1;
    clks(3);
    bus.load = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL abort_load_ignored: got ready %b expected 1", bus.ready); end
    clks(80);
    n_checks++; if (got_word.size() != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d words expected 0", got_word.size()); end
    enable = 1'b1;
    clks(2);
    send(16'h8001, ok);
    wait_words(1, 300, ok);
    clks(80);
    n_checks++; if (got_word.size() != 1) begin n_fail++; $display("FAIL abort_resend_count: got %0d expected 1", got_word.size()); end
    else if (got_word[0] !== 16'h8001 || !got_steady[0]) begin n_fail++; $display("FAIL abort_resend_word: got %0h expected 8001", got_word[0]); end
  endtask

  task automatic test_reset_midword();
    bit ok;
    clear_logs();
    send(16'hFFFF, ok);
    clks(20);
    send(16'h0F0F, ok);
    clks(3);
    n_checks++; if (pwm !== 1'b1 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre: got pwm %b ready %b expected 1 0", pwm, bus.ready); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", bus.ready); end
    n_checks++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pwm: got %b expected 0", pwm); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
    n_checks++; if (aud_sd !== 1'b0) begin n_fail++; $display("FAIL rst_mid_aud_sd: got %b expected 0", aud_sd); end
`ifdef SERIALIZER_UNDERRUN_EN
    n_checks++; if (underrun !== 16'h0) begin n_fail++; $display("FAIL rst_mid_underrun: got %0h expected 0", underrun); end
`endif
    @(negedge clock);
    reset = 1'b0;
    clks(100);
    n_checks++; if (got_word.size() != 0) begin n_fail++; $display("FAIL rst_mid_discard: got %0d words expected 0", got_word.size()); end
  endtask

  task automatic test_underrun();
`ifdef SERIALIZER_UNDERRUN_EN
    bit ok;
    int bad;
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      send(16'($urandom()), ok);
      wait_words(k + 1, 300, ok);
      clks(20);
    end
    bad = 0;
    for (int i = 0; i < 3 && i < got_word.size(); i++)
      if (got_word[i] !== exp_q[i]) bad++;
    n_checks++; if (got_word.size() != 3 || bad != 0) begin n_fail++; $display("FAIL underrun_words: got %0d words %0d bad expected 3 0", got_word.size(), bad); end
    n_checks++; if (underrun !== 16'd3) begin n_fail++; $display("FAIL underrun_count: got %0d expected 3", underrun); end
    enable = 1'b0;
    clks(3);
    n_checks++; if (underrun !== 16'd3) begin n_fail++; $display("FAIL underrun_hold_disabled: got %0d expected 3", underrun); end
    enable = 1'b1;
    clks(2);
`endif
  endtask

  task automatic test_lsb_first();
    logic [15:0] w;
    logic        s [0:WCLK];
    logic        d [0:WCLK];
    int c, bad, dpos;
    w = 16'h0001;
    lbus.data = w;
    lbus.load = 1'b1;
    @(negedge clock);
    lbus.load = 1'b0;
    c = 1;
    while (pwm_l !== 1'b1 && c < 10) begin
      @(negedge clock);
      c++;
    end
    n_checks++; if ((c - 1) < 1 || (c - 1) > DIV) begin n_fail++; $display("FAIL lsb_latency: got %0d expected 1..%0d", c - 1, DIV); end
    for (int i = 0; i <= WCLK; i++) begin
      s[i] = pwm_l;
      d[i] = done_l;
      if (i < WCLK) @(negedge clock);
    end
    bad = 0;
    dpos = -1;
    for (int i = 0; i < WCLK; i++)
      if (s[i] !== w[i / DIV]) bad++;
    for (int i = 0; i <= WCLK; i++)
      if (d[i] === 1'b1 && dpos < 0) dpos = i;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lsb_waveform: got %0d bad samples expected 0", bad); end
    n_checks++; if (dpos != WCLK) begin n_fail++; $display("FAIL lsb_done_pos: got %0d expected %0d", dpos, WCLK); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_midword();
    test_underrun();
    test_lsb_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
